wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
//  Writeback-side driver of the register file write port (RDaddr/RDdata/RegWrite).
//  Merges the fixed-latency ALU result stream with variable-latency data-memory load
//  returns onto the single write port. ALU always wins; load returns wait in a small FIFO.
//  Exports a pending-write mask so decode can stall on registers with buffered loads.
// PARAMETERS
//  DEPTH   4   load-return FIFO entries; power of two, >=2
//  AW      2   log2(DEPTH); FIFO pointer width
// PORTS
//  clk_i         in   1   clock
//  rst_i         in   1   asynchronous reset, active-high
//  alu_valid_i   in   1   ALU result valid this cycle; cannot be back-pressured
//  alu_rd_i      in   5   ALU destination register
//  alu_data_i    in   32  ALU result
//  mem_valid_i   in   1   load return valid
//  mem_rd_i      in   5   load destination register
//  mem_data_i    in   32  load data
//  mem_ready_o   out  1   FIFO can accept; a load transfers on mem_valid_i & mem_ready_o
//  RegWrite_o    out  1   register file write enable (registered)
//  RDaddr_o      out  5   register file write address (registered)
//  RDdata_o      out  32  register file write data (registered)
//  pending_o     out  32  bit r set = live buffered load to register r
// BEHAVIOUR
//  Reset (async): RegWrite_o=0, RDaddr_o=0, RDdata_o=0, FIFO empty, all kill bits clear,
//   pending_o=0, mem_ready_o=1. Reset mid-operation discards all buffered loads.
//  A write to r0 is never issued. alu_rd_i=0 counts as ALU idle. A load with rd=0 is accepted and dropped.
//  Outputs are registered: selection in cycle N -> RegWrite_o/RDaddr_o/RDdata_o valid in N+1.
//   RegWrite_o is high for exactly one cycle per write.
//  Per-cycle selection, in priority order:
//   1. ALU active: write ALU result. An accepted load is enqueued.
//   2. ALU idle, FIFO non-empty: pop head. A live head is written. A killed head is
//      discarded with RegWrite_o=0 that cycle. An accepted load is enqueued.
//   3. ALU idle, FIFO empty, load accepted: bypass and write load directly (latency 1).
//   4. Otherwise: RegWrite_o=0 next cycle.
//  Ordering/kill rule: an active ALU write to rd=r sets the kill bit of every valid FIFO entry
//   with rd=r. A load arriving in the same cycle with rd=r is discarded, since the ALU op is younger.
//   FIFO order is preserved for live loads.
//  FIFO: mem_ready_o = (count < DEPTH), computed from current state only. It does not
//   anticipate a same-cycle pop. Simultaneous push+pop leaves count unchanged.
//   Pointers wrap modulo DEPTH. A load with mem_valid_i & !mem_ready_o is not taken.
//   The source must hold that load until it is accepted.
//  pending_o: OR over valid, non-killed FIFO entries of (1<<rd). It reflects state after the
//   last clock edge. Bypassed loads and loads in the output register are not pending,
//   because the register file forwards the write-cycle data.
//  No combinational path from any input to RegWrite_o/RDaddr_o/RDdata_o/mem_ready_o.
// TESTING
//  T1 alu_valid=1 rd=5 data=DEADBEEF, no load -> next cycle RegWrite=1 RDaddr=5
//     RDdata=DEADBEEF; following cycle RegWrite=0.
//  T2 same cycle ALU rd=3 data=1 and load rd=4 data=2 -> N+1 writes r3=1, pending_o=0x10;
//     N+2 writes r4=2, pending_o=0.
//  T3 load rd=7 data=AA buffered behind busy ALU, then ALU rd=7 data=BB -> r7=BB written,
//     pending_o[7] clears; the later pop gives RegWrite=0 and r7 is never written with AA.
//  T4 ALU busy for 6 cycles while loads rd=8..12 arrive back-to-back -> mem_ready_o low
//     after 4 accepts, rd=12 held; then writes r8,r9,r10,r11,r12 in order, one per cycle.
//  T5 ALU rd=0 and load rd=0 -> no RegWrite; load accepted, pending_o stays 0.
//  T6 assert rst_i async with 3 buffered loads -> outputs 0 and mem_ready_o=1 immediately,
//     no writes after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU result stream and buffered load returns onto the
// single register-file write port, and exports a pending-load mask for decode.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,
    input  logic        mem_valid_i,
    input  logic [4:0]  mem_rd_i,
    input  logic [31:0] mem_data_i,
    output logic        mem_ready_o,
    output logic        RegWrite_o,
    output logic [4:0]  RDaddr_o,
    output logic [31:0] RDdata_o,
    output logic [31:0] pending_o
);

    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d, kill_q, kill_d;
    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [AW:0]      count_q, count_d;
    logic             we_q, we_d;
    logic [4:0]       addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             alu_act, mem_acc, fifo_empty, push, pop;

    assign alu_act     = alu_valid_i && (alu_rd_i != 5'd0);
    assign mem_ready_o = count_q < (AW+1)'(DEPTH);
    assign mem_acc     = mem_valid_i && mem_ready_o;
    assign fifo_empty  = (count_q == '0);

    always_comb begin
        valid_d = valid_q;
        kill_d  = kill_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        push    = 1'b0;
        pop     = 1'b0;

        if (alu_act) begin
            we_d    = 1'b1;
            addr_d  = alu_rd_i;
            wdata_d = alu_data_i;
            // The ALU op is younger than any buffered or same-cycle load to the same rd.
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (rd_q[i] == alu_rd_i)) kill_d[i] = 1'b1;
            end
            push = mem_acc && (mem_rd_i != 5'd0) && (mem_rd_i != alu_rd_i);
        end else if (!fifo_empty) begin
            pop     = 1'b1;
            we_d    = !kill_q[head_q];
            addr_d  = rd_q[head_q];
            wdata_d = data_q[head_q];
            push    = mem_acc && (mem_rd_i != 5'd0);
        end else if (mem_acc && (mem_rd_i != 5'd0)) begin
            we_d    = 1'b1;
            addr_d  = mem_rd_i;
            wdata_d = mem_data_i;
        end

        if (pop) begin
            valid_d[head_q] = 1'b0;
            kill_d[head_q]  = 1'b0;
            head_d          = head_q + AW'(1);
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            kill_d[tail_q]  = 1'b0;
            tail_d          = tail_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            kill_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            kill_q  <= kill_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (push) begin
                rd_q[tail_q]   <= mem_rd_i;
                data_q[tail_q] <= mem_data_i;
            end
        end
    end

    always_comb begin
        pending_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !kill_q[i]) pending_o[rd_q[i]] = 1'b1;
        end
    end

    assign RegWrite_o = we_q;
    assign RDaddr_o   = addr_q;
    assign RDdata_o   = wdata_q;

endmodule
